mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequenced multiply/divide unit controller for the 5-stage pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the E-stage control word and models fixed multi-cycle latency with a busy flag.
- The stall controller holds any E-stage MDU instruction in D while busy; the forward muxes read HI/LO from hi/lo.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage command valid; low when E is a bubble
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
a  input  32  forwarded rs value (V1 after E forwarding)
b  input  32  forwarded rt value (V2 after E forwarding)
busy  output  1  operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result regs=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; cnt is a 4-bit down-counter.
- Accept condition: state==IDLE && start && op in {1..6}. When busy, start is ignored entirely. The stall controller must not present commands then; the bench checks that commands issued while busy have no effect.
- MULT accept (edge k): pend={a*b} signed 64-bit, MULTU unsigned; state->RUN, cnt=MULT_CYCLES-1.
- DIV accept: pend_lo=a/b, pend_hi=a%b, truncating toward zero. Signed for DIV, unsigned for DIVU. Remainder sign follows the dividend. state->RUN, cnt=DIV_CYCLES-1.
- Divide by zero (b==0): still runs DIV_CYCLES, but HI/LO stay unchanged on completion.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- RUN: each edge cnt-=1. On the edge where cnt==0, hi/lo<=pend (64-bit split: hi=[63:32], lo=[31:0]) and state->IDLE.
- Net timing: busy is high in exactly N cycles following the accept edge; the new hi/lo are visible in the first cycle busy is low again.
- MTHI/MTLO accept: hi<=a or lo<=a on the accept edge. State stays IDLE, busy never asserts.
- hi/lo are registered outputs that change only on the edges above. MFHI/MFLO read them through E forwarding; because busy stalls those instructions in D, reads never see a stale value.
- Reset asserted mid-RUN: immediate abort to reset values; pending result discarded.
- N=1: busy is high for exactly one cycle.

Optional Feature:
- Macro MDU_BUSY_LOOKAHEAD_EN.
- Defined: busy = (state==RUN) | (state==IDLE && start && op in {1..4}). Busy is then combinationally high in the accept cycle, so the stall controller can freeze D in the same cycle a MULT/DIV enters E.
- Undefined: busy is registered state only (RUN), and the stall controller must separately treat "E holds MULT/DIV" as busy.
- All other behaviour is identical in both builds.

Test Plan:
- reset low mid-RUN at cycle 3 of DIV -> busy=0, hi=lo=0 immediately (asynchronous), with no clock edge needed.
- MULT a=0xFFFFFFFE(-2), b=3, default params -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9(-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- Preload MTHI 0x1234 and MTLO 0x5678 (busy stays 0, values visible the next cycle); then DIV by b=0 -> busy 10 cycles, hi/lo still 0x1234/0x5678.
- MULT started, then start=1 op=MTLO a=0xDEAD at RUN cycle 2 -> ignored; lo equals the MULT result after completion, not 0xDEAD.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. With MDU_BUSY_LOOKAHEAD_EN, busy is also high in the accept cycle (11 high cycles total).

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the E stage and the multiply/divide unit.
// The master drives the command; the slave returns busy and the HI/LO values.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Sequenced MULT/DIV controller that owns HI/LO, with a fixed-latency busy flag.
// Optional MDU_BUSY_LOOKAHEAD_EN raises busy combinationally in the accept cycle.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [63:0] r_pend;
    logic        r_pend_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_busy;

    logic        w_idle;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_long;
    logic        w_done;

    assign w_idle   = (r_state == IDLE);
    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign w_long   = w_idle && bus.start && (w_is_mul || w_is_div);
    assign w_done   = (r_state == RUN) && (r_cnt == 4'd0);

    // Low 64 bits of a 64x64 product equal the 32x32 signed/unsigned product.
    logic [63:0] w_ea;
    logic [63:0] w_eb;
    logic [63:0] w_prod;
    logic        w_sgn_mul;

    assign w_sgn_mul = (bus.op == OP_MULT);
    assign w_ea   = {{32{w_sgn_mul & bus.a[31]}}, bus.a};
    assign w_eb   = {{32{w_sgn_mul & bus.b[31]}}, bus.b};
    assign w_prod = w_ea * w_eb;

    // Signed divide on magnitudes, then fix signs; 0x80000000/-1 falls out naturally.
    logic        w_sgn_div;
    logic        w_dz;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_sgn_div = (bus.op == OP_DIV);
    assign w_dz      = (bus.b == 32'd0);
    assign w_dvd = (w_sgn_div && bus.a[31]) ? -bus.a : bus.a;
    assign w_dvs = w_dz ? 32'd1 :
                   ((w_sgn_div && bus.b[31]) ? -bus.b : bus.b);
    assign w_uq  = w_dvd / w_dvs;
    assign w_ur  = w_dvd % w_dvs;
    assign w_q   = (w_sgn_div && (bus.a[31] ^ bus.b[31])) ? -w_uq : w_uq;
    assign w_r   = (w_sgn_div && bus.a[31]) ? -w_ur : w_ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_long) w_next = RUN;
            RUN:  if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
`ifdef MDU_BUSY_LOOKAHEAD_EN
        w_busy = w_busy | w_long;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_pend    <= 64'd0;
            r_pend_we <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_long) begin
                r_cnt     <= w_is_mul ? MUL_LAST : DIV_LAST;
                r_pend    <= w_is_mul ? w_prod : {w_r, w_q};
                r_pend_we <= w_is_mul || !w_dz;
            end else if (r_state == RUN && !w_done) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && r_pend_we) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
            if (w_idle && bus.start && bus.op == OP_MTHI) r_hi <= bus.a;
            if (w_idle && bus.start && bus.op == OP_MTLO) r_lo <= bus.a;
        end
    end

    assign bus.busy = w_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: scoreboard of expected HI/LO, busy-length checks.
// Build with MDU_BUSY_LOOKAHEAD_EN to exercise the accept-cycle busy path.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MDU_BUSY_LOOKAHEAD_EN
    localparam bit LA = 1'b1;
`else
    localparam bit LA = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Drive one command, count busy cycles, then check HI/LO against the scoreboard.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [63:0] exp,
                          input bit inject);
        int cnt;
        logic [63:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        chk({tag, "_busy_acc"}, {63'd0, bus.busy}, {63'd0, LA && (n > 0)});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inject) begin
                bus.start = 1'b0;
                bus.op    = 3'd0;
            end
            if (!bus.busy) break;
            cnt++;
            if (inject && cnt == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd6;
                bus.a     = 32'hDEAD;
            end
        end
        chk({tag, "_busy_len"}, 64'(cnt), 64'(n));
        e = sb_q.pop_front();
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        int cnt;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;

        run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 64'hFFFFFFFF_FFFFFFFA, 0);
        run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 64'h00000002_FFFFFFFA, 0);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_op("divu",  3'd4, 32'd7, 32'd2, 10, 64'h00000001_00000003, 0);
        run_op("mthi",  3'd5, 32'h1234, 32'd0, 0, {32'h1234, m_lo}, 0);
        run_op("mtlo",  3'd6, 32'h5678, 32'd0, 0, {32'h1234, 32'h5678}, 0);
        run_op("div0",  3'd3, 32'd99, 32'd0, 10, {m_hi, m_lo}, 0);
        run_op("inj",   3'd1, 32'd100, 32'd200, 5, 64'h00000000_00004E20, 1);
        run_op("ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000, 0);
        run_op("op7",   3'd7, 32'hBEEF, 32'd1, 0, {m_hi, m_lo}, 0);

        // Abort a DIV after 3 busy cycles with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        chk("abort_pre_busy", 64'(cnt), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;

        run_op("post", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 64'hFFFFFFFE_00000001, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
